// File: rtl/vga_pkg.sv
// Shared VGA definitions: default bus widths, layer mode encodings and the
// timing bundle passed between the draw_* stages and the layer mixer.
package vga_pkg;

  // Default widths used by the draw pipeline.
  localparam int VGA_CNT_W   = 12;
  localparam int VGA_COLOR_W = 12;

  // Per-layer compositing modes.
  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_OPAQUE = 2'b01;
  localparam logic [1:0] MODE_BLEND  = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  // Timing bundle that travels alongside the pixel data.
  typedef struct packed {
    logic [VGA_CNT_W-1:0] hcount;
    logic [VGA_CNT_W-1:0] vcount;
    logic                 hsync;
    logic                 vsync;
    logic                 hblnk;
    logic                 vblnk;
  } vga_timing_t;

  // True when the pixel lies in either blanking interval.
  function automatic logic timing_blank(input vga_timing_t t);
    return t.hblnk | t.vblnk;
  endfunction

endpackage

// File: rtl/vga_layer_op.sv
// Single-layer combine step of the compositor (purely combinational).
//   acc         : colour accumulated from the layers below
//   pix         : this layer's pixel
//   mode        : this layer's active mode (OFF / OPAQUE / BLEND / BLINK)
//   blink_phase : 1 = blinking layers are visible
//   acc_next    : accumulator handed to the layer above
module vga_layer_op
  import vga_pkg::*;
#(
  parameter int                 COLOR_W = VGA_COLOR_W,
  parameter logic [COLOR_W-1:0] KEY     = {COLOR_W{1'b0}}
) (
  input  logic [COLOR_W-1:0] acc,
  input  logic [COLOR_W-1:0] pix,
  input  logic [1:0]         mode,
  input  logic               blink_phase,
  output logic [COLOR_W-1:0] acc_next
);

  localparam int CH_W = COLOR_W / 3;

  logic [COLOR_W-1:0] blend_s;
  logic               visible_s;

  // Floored average of two channels; the extra sum bit keeps the carry.
  function automatic logic [CH_W-1:0] avg_ch(input logic [CH_W-1:0] a,
                                              input logic [CH_W-1:0] b);
    logic [CH_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CH_W:1];
  endfunction

  assign visible_s = (pix != KEY);

  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign blend_s[c*CH_W +: CH_W] = avg_ch(acc[c*CH_W +: CH_W], pix[c*CH_W +: CH_W]);
  end

  // Select the accumulator update for this layer; keyed pixels pass acc through.
  always_comb begin
    acc_next = acc;
    if (visible_s) begin
      case (mode)
        MODE_OFF:    acc_next = acc;
        MODE_OPAQUE: acc_next = pix;
        MODE_BLEND:  acc_next = blend_s;
        MODE_BLINK: begin
          if (blink_phase) begin
            acc_next = pix;
          end else begin
            acc_next = acc;
          end
        end
        default:     acc_next = acc;
      endcase
    end else begin
      acc_next = acc;
    end
  end

endmodule

// File: rtl/vga_layer_mixer.sv
// N-layer pixel compositor with frame-synchronous mode switching and blink.
// Two-stage pipeline: stage 1 registers inputs and flags the vsync rising
// edge, stage 2 registers the folded pixel and the delayed timing.
// Ports:
//   pclk, rst           : pixel clock, asynchronous active-low reset
//   hcount_in..vblnk_in : input timing bundle
//   rgb_in              : LAYERS pixels, layer k at [k*COLOR_W +: COLOR_W]
//   layer_mode_in       : requested mode per layer, layer k at [2k +: 2]
//   *_out               : timing delayed by 2 cycles, composited rgb_out
//   frame_tick_out      : one-cycle pulse with the rising edge of vsync_out
module vga_layer_mixer
  import vga_pkg::*;
#(
  parameter int                  LAYERS       = 4,
  parameter int                  COLOR_W      = VGA_COLOR_W,
  parameter int                  CNT_W        = VGA_CNT_W,
  parameter logic [COLOR_W-1:0]  KEY          = {COLOR_W{1'b0}},
  parameter int                  BLINK_FRAMES = 30,
  parameter logic [2*LAYERS-1:0] RESET_MODE   = {LAYERS{2'b01}}
) (
  input  logic                        pclk,
  input  logic                        rst,
  input  logic [CNT_W-1:0]            hcount_in,
  input  logic [CNT_W-1:0]            vcount_in,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        hblnk_in,
  input  logic                        vblnk_in,
  input  logic [LAYERS*COLOR_W-1:0]   rgb_in,
  input  logic [2*LAYERS-1:0]         layer_mode_in,
  output logic [CNT_W-1:0]            hcount_out,
  output logic [CNT_W-1:0]            vcount_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        hblnk_out,
  output logic                        vblnk_out,
  output logic [COLOR_W-1:0]          rgb_out,
  output logic                        frame_tick_out
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  if (COLOR_W % 3 != 0) begin : g_err_color
    $error("vga_layer_mixer: COLOR_W must be a multiple of 3");
  end
  if (LAYERS < 1) begin : g_err_layers
    $error("vga_layer_mixer: LAYERS must be at least 1");
  end
  if (BLINK_FRAMES < 1) begin : g_err_blink
    $error("vga_layer_mixer: BLINK_FRAMES must be at least 1");
  end
  // The shared timing bundle has fixed-width counters.
  if (CNT_W != VGA_CNT_W) begin : g_err_cnt
    $error("vga_layer_mixer: CNT_W must match the vga_pkg timing bundle");
  end

  vga_timing_t                tim_in_s;
  vga_timing_t                tim1_r;
  logic [LAYERS*COLOR_W-1:0]  rgb1_r;
  logic [2*LAYERS-1:0]        mode_req1_r;
  logic [2*LAYERS-1:0]        mode_r;
  logic                       edge1_r;
  logic                       vsync_d_r;
  logic                       edge_s;
  logic                       blink_phase_r;
  logic [FC_W-1:0]            frame_cnt_r;
  logic [COLOR_W-1:0]         acc_s [LAYERS+1];
  logic [COLOR_W-1:0]         pix_s;

  assign tim_in_s = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
  assign edge_s   = vsync_in & ~vsync_d_r;

  // Stage 1: register inputs, requested modes and the vsync rising-edge flag.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      tim1_r      <= '0;
      rgb1_r      <= {(LAYERS*COLOR_W){1'b0}};
      mode_req1_r <= {(2*LAYERS){1'b0}};
      edge1_r     <= 1'b0;
      vsync_d_r   <= 1'b0;
    end else begin
      tim1_r      <= tim_in_s;
      rgb1_r      <= rgb_in;
      mode_req1_r <= layer_mode_in;
      edge1_r     <= edge_s;
      vsync_d_r   <= vsync_in;
    end
  end

  // Active modes and blink phase change together, only when the edge pixel
  // is in stage 1, so the edge pixel itself still uses the old settings.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      mode_r        <= RESET_MODE;
      frame_cnt_r   <= {FC_W{1'b0}};
      blink_phase_r <= 1'b1;
    end else if (edge1_r) begin
      mode_r <= mode_req1_r;
      if (frame_cnt_r == FC_LAST) begin
        frame_cnt_r   <= {FC_W{1'b0}};
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Bottom-up fold: layer 0 sees an empty (zero) accumulator.
  assign acc_s[0] = {COLOR_W{1'b0}};

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    vga_layer_op #(
      .COLOR_W (COLOR_W),
      .KEY     (KEY)
    ) u_op (
      .acc         (acc_s[k]),
      .pix         (rgb1_r[k*COLOR_W +: COLOR_W]),
      .mode        (mode_r[2*k +: 2]),
      .blink_phase (blink_phase_r),
      .acc_next    (acc_s[k+1])
    );
  end

  // Force black during blanking regardless of the layer contents.
  always_comb begin
    pix_s = acc_s[LAYERS];
    if (timing_blank(tim1_r)) begin
      pix_s = {COLOR_W{1'b0}};
    end else begin
      pix_s = acc_s[LAYERS];
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_out     <= {CNT_W{1'b0}};
      vcount_out     <= {CNT_W{1'b0}};
      hsync_out      <= 1'b0;
      vsync_out      <= 1'b0;
      hblnk_out      <= 1'b0;
      vblnk_out      <= 1'b0;
      rgb_out        <= {COLOR_W{1'b0}};
      frame_tick_out <= 1'b0;
    end else begin
      hcount_out     <= tim1_r.hcount;
      vcount_out     <= tim1_r.vcount;
      hsync_out      <= tim1_r.hsync;
      vsync_out      <= tim1_r.vsync;
      hblnk_out      <= tim1_r.hblnk;
      vblnk_out      <= tim1_r.vblnk;
      rgb_out        <= pix_s;
      frame_tick_out <= edge1_r;
    end
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Self-checking bench for vga_layer_mixer: a small raster generator drives
// the DUT, a per-pixel reference model predicts every output two cycles
// later, and directed scenarios add fixed expected colours.
module tb_vga_layer_mixer;

  localparam int          LAYERS       = 4;
  localparam int          BLINK_FRAMES = 2;
  localparam logic [11:0] KEY          = 12'h000;
  localparam logic [7:0]  RESET_MODE   = 8'h55;

  // Miniature raster: 40 x 12 cycles per frame.
  localparam int H_TOTAL = 40, H_ACT = 32, HS_START = 34, HS_END = 37;
  localparam int V_TOTAL = 12, V_ACT = 8,  VS_START = 9,  VS_END = 11;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [11:0] hcount_in = 12'h000, vcount_in = 12'h000;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [47:0] rgb_in = 48'h0;
  logic [7:0]  layer_mode_in = 8'h00;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, frame_tick_out;

  vga_layer_mixer #(
    .LAYERS       (LAYERS),
    .COLOR_W      (12),
    .CNT_W        (12),
    .KEY          (KEY),
    .BLINK_FRAMES (BLINK_FRAMES),
    .RESET_MODE   (RESET_MODE)
  ) dut (
    .pclk           (pclk),
    .rst            (rst),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .hblnk_in       (hblnk_in),
    .vblnk_in       (vblnk_in),
    .rgb_in         (rgb_in),
    .layer_mode_in  (layer_mode_in),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .hblnk_out      (hblnk_out),
    .vblnk_out      (vblnk_out),
    .rgb_out        (rgb_out),
    .frame_tick_out (frame_tick_out)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [11:0] hc;
    logic [11:0] vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        tick;
    logic        has_dir;
    logic [11:0] dir;
  } exp_t;

  exp_t exp_d1 = '0, exp_d2 = '0;
  int   n_checks = 0, n_fail = 0;
  int   hc = 10, vc = 3;

  // Reference model state: active modes, vsync edges since reset, last vsync.
  logic [7:0] m_modes = RESET_MODE;
  int         m_edges = 0;
  logic       m_prev_vs = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Composite one pixel straight from the mode rules using integer channels.
  function automatic logic [11:0] model_pix(input logic [47:0] rgb, input logic [7:0] modes,
                                            input logic phase, input logic blank);
    int r, g, b;
    logic [11:0] p;
    logic [1:0]  m;
    r = 0; g = 0; b = 0;
    if (blank) return 12'h000;
    for (int k = 0; k < LAYERS; k++) begin
      p = rgb[k*12 +: 12];
      m = modes[2*k +: 2];
      if (p != KEY) begin
        if (m == 2'b01 || (m == 2'b11 && phase)) begin
          r = int'(p[11:8]); g = int'(p[7:4]); b = int'(p[3:0]);
        end else if (m == 2'b10) begin
          r = (r + int'(p[11:8])) / 2;
          g = (g + int'(p[7:4])) / 2;
          b = (b + int'(p[3:0])) / 2;
        end
      end
    end
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  function automatic logic [11:0] rand_layer();
    logic [11:0] v;
    v = 12'($urandom);
    if ($urandom_range(0, 3) == 0) v = KEY;
    return v;
  endfunction

  task automatic check_outputs();
    check_val("rgb_out",    32'(rgb_out),        32'(exp_d2.rgb));
    check_val("hcount_out", 32'(hcount_out),     32'(exp_d2.hc));
    check_val("vcount_out", 32'(vcount_out),     32'(exp_d2.vc));
    check_val("hsync_out",  32'(hsync_out),      32'(exp_d2.hs));
    check_val("vsync_out",  32'(vsync_out),      32'(exp_d2.vs));
    check_val("hblnk_out",  32'(hblnk_out),      32'(exp_d2.hb));
    check_val("vblnk_out",  32'(vblnk_out),      32'(exp_d2.vb));
    check_val("frame_tick", 32'(frame_tick_out), 32'(exp_d2.tick));
    if (exp_d2.has_dir) check_val("directed_rgb", 32'(rgb_out), 32'(exp_d2.dir));
  endtask

  // One pixel cycle: check outputs at the falling edge, then drive the next pixel.
  task automatic drive_cycle(input logic rst_val, input logic [47:0] rgb, input logic [7:0] mode,
                             input logic has_dir, input logic [11:0] dir_rgb);
    exp_t e;
    logic hs, vs, hb, vb, phase;
    @(negedge pclk);
    check_outputs();
    if (rst && !rst_val) begin
      rst = 1'b0;
      #1;
      check_val("rst_rgb",    32'(rgb_out),        32'd0);
      check_val("rst_hcount", 32'(hcount_out),     32'd0);
      check_val("rst_vsync",  32'(vsync_out),      32'd0);
      check_val("rst_tick",   32'(frame_tick_out), 32'd0);
    end else begin
      rst = rst_val;
    end
    hs = (hc >= HS_START) && (hc < HS_END);
    vs = (vc >= VS_START) && (vc < VS_END);
    hb = (hc >= H_ACT);
    vb = (vc >= V_ACT);
    hcount_in = hc[11:0]; vcount_in = vc[11:0];
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    rgb_in = rgb; layer_mode_in = mode;
    e = '0;
    if (!rst_val) begin
      m_modes = RESET_MODE; m_edges = 0; m_prev_vs = 1'b0;
      exp_d1 = '0;
    end else begin
      phase     = ((m_edges / BLINK_FRAMES) % 2) == 0;
      e.hc      = hc[11:0]; e.vc = vc[11:0];
      e.hs      = hs; e.vs = vs; e.hb = hb; e.vb = vb;
      e.rgb     = model_pix(rgb, m_modes, phase, hb | vb);
      e.tick    = vs & ~m_prev_vs;
      e.has_dir = has_dir;
      e.dir     = (hb | vb) ? 12'h000 : dir_rgb;
      if (e.tick) begin
        m_modes = mode;
        m_edges++;
      end
      m_prev_vs = vs;
    end
    exp_d2 = exp_d1;
    exp_d1 = e;
    hc++;
    if (hc == H_TOTAL) begin
      hc = 0;
      vc++;
      if (vc == V_TOTAL) vc = 0;
    end
  endtask

  initial begin
    logic [7:0]  cur_mode;
    logic        switched, seen_edge, edge_now, rst_val;
    logic [11:0] dir;

    rst = 1'b0;

    // Reset held mid-line with busy inputs.
    for (int i = 0; i < 6; i++)
      drive_cycle(1'b0, {rand_layer(), rand_layer(), rand_layer(), rand_layer()},
                  8'($urandom), 1'b0, 12'h000);

    // All opaque (reset modes): top keyed, layer2 red wins.
    for (int i = 0; i < 60; i++)
      drive_cycle(1'b1, {12'h000, 12'hF00, 12'h0F0, 12'h0F0}, 8'h55, 1'b1, 12'hF00);

    // Blend red over green once the new modes are active.
    for (int i = 0; i < 600; i++)
      drive_cycle(1'b1, {12'hFFF, 12'hFFF, 12'hF00, 12'h0F0}, 8'h09,
                  (m_modes == 8'h09), 12'h770);

    // Blink red over blue, two frames per half-period.
    for (int i = 0; i < 5 * H_TOTAL * V_TOTAL; i++) begin
      dir = (((m_edges / BLINK_FRAMES) % 2) == 0) ? 12'hF00 : 12'h00F;
      drive_cycle(1'b1, {12'h000, 12'h000, 12'hF00, 12'h00F}, 8'h0D, (m_modes == 8'h0D), dir);
    end

    // Shadow: turn layer2 off mid-frame; visible only after the next vsync edge.
    switched = 1'b0; seen_edge = 1'b0;
    for (int i = 0; i < 3 * H_TOTAL * V_TOTAL; i++) begin
      if (!switched && vc == 4 && hc == 20 && m_modes == 8'h55) switched = 1'b1;
      edge_now = (vc == VS_START) && (hc == 0);
      dir = seen_edge ? 12'hF00 : 12'h00F;
      drive_cycle(1'b1, {12'h000, 12'h00F, 12'h000, 12'hF00}, switched ? 8'h45 : 8'h55,
                  switched || (m_modes == 8'h55), dir);
      if (switched && edge_now) seen_edge = 1'b1;
    end

    // Blanking with all layers white.
    for (int i = 0; i < 2 * H_TOTAL * V_TOTAL; i++)
      drive_cycle(1'b1, {4{12'hFFF}}, 8'h55, (m_modes == 8'h55), 12'hFFF);

    // Random layers and modes, mode changes on edge cycles, one mid-frame reset.
    cur_mode = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) cur_mode = 8'($urandom);
      if (vc == VS_START && hc == 0 && $urandom_range(0, 1) == 1) cur_mode = 8'($urandom);
      rst_val = !(i >= 1500 && i < 1504);
      drive_cycle(rst_val, {rand_layer(), rand_layer(), rand_layer(), rand_layer()},
                  cur_mode, 1'b0, 12'h000);
    end

    // Drain the pipeline.
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 48'h0, cur_mode, 1'b0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
